// File: rtl/qinj_pulse_gen.sv
// ---------------------------------------------------------------------------
// qinj_pulse_gen
//
// Charge-injection pulse sequencer feeding the ChargeInj_IN input of the
// 16x16 clock-tree fan-out. A single-cycle trigger is turned into a train of
// pulses aligned to CLK40: start delay, pulse width, gap and pulse count.
// All timing is whole CLK40 cycles; the clock tree adds its own fixed delay.
//
// Parameters
//   DLY_W  width of cfgDelay / cfgGap (cycles)
//   WID_W  width of cfgWidth (cycles)
//   CNT_W  width of cfgRepeat and of the pulse counter
//
// Ports
//   CLK40      in   40 MHz clock, all state on the rising edge
//   RSTN       in   asynchronous active-low reset
//   QInjEn     in   global enable; low blocks triggers and aborts a train
//   trigger    in   one-cycle injection request
//   cfgDelay   in   idle cycles between acceptance and the first pulse
//   cfgWidth   in   pulse high time in cycles (0 behaves as 1)
//   cfgGap     in   low time between pulses in cycles (0 behaves as 1)
//   cfgRepeat  in   number of pulses (0 behaves as 1)
//   ChargeInj  out  registered pulse train to the clock tree
//   busy       out  high while a train is in progress
//   done       out  one-cycle pulse on normal completion
//   dropCount  out  saturating count of ignored triggers (only with
//                   QINJ_DROP_COUNT_EN defined)
//
// Build option
//   QINJ_DROP_COUNT_EN  adds the dropCount output and its counter.
// ---------------------------------------------------------------------------
module qinj_pulse_gen #(
  parameter int unsigned DLY_W = 8,
  parameter int unsigned WID_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK40,
  input  logic             RSTN,
  input  logic             QInjEn,
  input  logic             trigger,
  input  logic [DLY_W-1:0] cfgDelay,
  input  logic [WID_W-1:0] cfgWidth,
  input  logic [DLY_W-1:0] cfgGap,
  input  logic [CNT_W-1:0] cfgRepeat,
  output logic             ChargeInj,
  output logic             busy,
`ifdef QINJ_DROP_COUNT_EN
  output logic             done,
  output logic [7:0]       dropCount
`else
  output logic             done
`endif
);

  // Shared down-counter wide enough for delay, width and gap intervals.
  localparam int unsigned TW = (DLY_W > WID_W) ? DLY_W : WID_W;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StHigh,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           r_state;
  logic [TW-1:0]    r_timer;   // cycles left in the current phase, minus one
  logic [WID_W-1:0] r_wid_m1;  // shadow: effective width minus one
  logic [DLY_W-1:0] r_gap_m1;  // shadow: effective gap minus one
  logic [CNT_W-1:0] r_rem;     // pulses still to issue after the current one
  logic             r_ci;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_nxt;
  logic [TW-1:0]    w_timer_nxt;
  logic [WID_W-1:0] w_wid_nxt;
  logic [DLY_W-1:0] w_gap_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_ci_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // ---------------------------------------------------------------------------
  // Effective configuration, zero fields treated as one and stored minus one.
  // A delay of 0 or 1 both give the minimum one-cycle latency.
  // ---------------------------------------------------------------------------
  logic [DLY_W-1:0] w_dly_m1;
  logic [WID_W-1:0] w_cfg_wid_m1;
  logic [DLY_W-1:0] w_cfg_gap_m1;
  logic [CNT_W-1:0] w_cfg_rem;
  logic             w_timer_zero;
  logic             w_accept;
  logic             w_abort;

  assign w_dly_m1     = (cfgDelay  == '0) ? '0 : cfgDelay  - DLY_W'(1);
  assign w_cfg_wid_m1 = (cfgWidth  == '0) ? '0 : cfgWidth  - WID_W'(1);
  assign w_cfg_gap_m1 = (cfgGap    == '0) ? '0 : cfgGap    - DLY_W'(1);
  assign w_cfg_rem    = (cfgRepeat == '0) ? '0 : cfgRepeat - CNT_W'(1);

  assign w_timer_zero = (r_timer == '0);
  assign w_accept     = (r_state == StIdle) && trigger && QInjEn;
  assign w_abort      = (r_state != StIdle) && !QInjEn;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_wid_nxt   = r_wid_m1;
    w_gap_nxt   = r_gap_m1;
    w_rem_nxt   = r_rem;
    w_ci_nxt    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StDelay;
          w_timer_nxt = TW'(w_dly_m1);
          w_wid_nxt   = w_cfg_wid_m1;
          w_gap_nxt   = w_cfg_gap_m1;
          w_rem_nxt   = w_cfg_rem;
          w_busy_nxt  = 1'b1;
        end
      end

      StDelay: begin
        w_busy_nxt = 1'b1;
        if (w_timer_zero) begin
          w_state_nxt = StHigh;
          w_timer_nxt = TW'(r_wid_m1);
          w_ci_nxt    = 1'b1;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      StHigh: begin
        if (!w_timer_zero) begin
          w_timer_nxt = r_timer - TW'(1);
          w_ci_nxt    = 1'b1;
          w_busy_nxt  = 1'b1;
        end else if (r_rem != '0) begin
          w_state_nxt = StGap;
          w_timer_nxt = TW'(r_gap_m1);
          w_rem_nxt   = r_rem - CNT_W'(1);
          w_busy_nxt  = 1'b1;
        end else begin
          // Last falling edge: train completes here.
          w_state_nxt = StIdle;
          w_timer_nxt = '0;
          w_done_nxt  = 1'b1;
        end
      end

      StGap: begin
        w_busy_nxt = 1'b1;
        if (w_timer_zero) begin
          w_state_nxt = StHigh;
          w_timer_nxt = TW'(r_wid_m1);
          w_ci_nxt    = 1'b1;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      default: begin
        w_state_nxt = StIdle;
        w_timer_nxt = '0;
      end
    endcase

    // Disable wins over everything, including a completion on the same edge.
    if (w_abort) begin
      w_state_nxt = StIdle;
      w_timer_nxt = '0;
      w_rem_nxt   = '0;
      w_ci_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK40 or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= StIdle;
      r_timer  <= '0;
      r_wid_m1 <= '0;
      r_gap_m1 <= '0;
      r_rem    <= '0;
      r_ci     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_wid_m1 <= w_wid_nxt;
      r_gap_m1 <= w_gap_nxt;
      r_rem    <= w_rem_nxt;
      r_ci     <= w_ci_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ChargeInj = r_ci;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef QINJ_DROP_COUNT_EN
  // ---------------------------------------------------------------------------
  // Ignored-trigger counter: a trigger is dropped when a train is already
  // running (including its completion edge) or when injection is disabled.
  // ---------------------------------------------------------------------------
  logic       w_drop;
  logic [7:0] r_drop_cnt;

  assign w_drop = trigger && (!QInjEn || (r_state != StIdle));

  always_ff @(posedge CLK40 or negedge RSTN) begin
    if (!RSTN) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign dropCount = r_drop_cnt;
`endif

endmodule

// File: tb/tb_qinj_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_qinj_pulse_gen
//
// Scoreboard bench for qinj_pulse_gen. Each clock edge the stimulus process
// evaluates a timeline model of the pulse train (start cycle, period, count)
// and queues the expected outputs; a monitor on the falling edge pops and
// compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_qinj_pulse_gen;

  logic       clk;
  logic       rstn;
  logic       qinj_en;
  logic       trig;
  logic [7:0] cfg_delay;
  logic [3:0] cfg_width;
  logic [7:0] cfg_gap;
  logic [7:0] cfg_repeat;
  logic       charge_inj;
  logic       busy;
  logic       done;
`ifdef QINJ_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  qinj_pulse_gen #(
    .DLY_W(8),
    .WID_W(4),
    .CNT_W(8)
  ) u_dut (
    .CLK40    (clk),
    .RSTN     (rstn),
    .QInjEn   (qinj_en),
    .trigger  (trig),
    .cfgDelay (cfg_delay),
    .cfgWidth (cfg_width),
    .cfgGap   (cfg_gap),
    .cfgRepeat(cfg_repeat),
    .ChargeInj(charge_inj),
    .busy     (busy),
`ifdef QINJ_DROP_COUNT_EN
    .done     (done),
    .dropCount(drop_count)
`else
    .done     (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit ci;
    bit busy;
    bit done;
    int drop;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endfunction

  // Timeline model: a train accepted at cycle m_k rises at m_k+m_d+i*(W+G)
  // for i in 0..R-1, each pulse lasting W cycles, and ends at m_end.
  bit m_active;
  int m_cyc;
  int m_k;
  int m_d;
  int m_w;
  int m_g;
  int m_r;
  int m_end;
  int m_drop;

  function automatic void model_reset();
    m_active = 1'b0;
    m_drop   = 0;
  endfunction

  function automatic void model_step(input bit t, input bit en);
    exp_t e;
    bit   done_now;
    int   off;
    done_now = 1'b0;
    if (t && (m_active || !en) && (m_drop < 255)) m_drop++;
    if (m_active && !en) begin
      m_active = 1'b0;
    end else if (m_active && (m_cyc == m_end)) begin
      m_active = 1'b0;
      done_now = 1'b1;
    end else if (!m_active && t && en) begin
      m_active = 1'b1;
      m_k      = m_cyc;
      m_d      = (cfg_delay  == 0) ? 1 : int'(cfg_delay);
      m_w      = (cfg_width  == 0) ? 1 : int'(cfg_width);
      m_g      = (cfg_gap    == 0) ? 1 : int'(cfg_gap);
      m_r      = (cfg_repeat == 0) ? 1 : int'(cfg_repeat);
      m_end    = m_k + m_d + (m_r - 1) * (m_w + m_g) + m_w;
    end
    e.ci = 1'b0;
    if (m_active) begin
      off = m_cyc - m_k - m_d;
      if (off >= 0 && (off % (m_w + m_g)) < m_w) e.ci = 1'b1;
    end
    e.busy = m_active;
    e.done = done_now;
    e.drop = m_drop;
    q.push_back(e);
    m_cyc++;
  endfunction

  // One clock cycle of stimulus; inputs change 1 time unit after an edge.
  task automatic cyc(input bit t, input bit en);
    trig    = t;
    qinj_en = en;
    @(posedge clk);
    model_step(t, en);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  task automatic set_cfg(input int d, input int w, input int g, input int r);
    cfg_delay  = 8'(d);
    cfg_width  = 4'(w);
    cfg_gap    = 8'(g);
    cfg_repeat = 8'(r);
  endtask

  // Reset pulse placed between edges, after the monitor has sampled.
  task automatic async_reset_mid();
    #5;
    rstn = 1'b0;
    #1;
    chk("async_rst_ChargeInj", int'(charge_inj), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    model_reset();
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: compares every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ChargeInj", int'(charge_inj), int'(e.ci));
        chk("busy", int'(busy), int'(e.busy));
        chk("done", int'(done), int'(e.done));
`ifdef QINJ_DROP_COUNT_EN
        chk("dropCount", int'(drop_count), e.drop);
`endif
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    qinj_en = 1'b0;
    trig    = 1'b0;
    set_cfg(0, 0, 0, 0);
    m_cyc = 0;
    model_reset();
    #3;
    chk("reset_ChargeInj", int'(charge_inj), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
`ifdef QINJ_DROP_COUNT_EN
    chk("reset_dropCount", int'(drop_count), 0);
`endif
    #1;
    rstn = 1'b1;

    // Basic single pulse.
    set_cfg(3, 2, 0, 1);
    idle(10);
    cyc(1'b1, 1'b1);
    idle(12);

    // All-zero configuration: one pulse of one cycle after one cycle.
    set_cfg(0, 0, 0, 0);
    cyc(1'b1, 1'b1);
    idle(6);

    // Four-pulse train.
    set_cfg(1, 1, 2, 4);
    cyc(1'b1, 1'b1);
    idle(14);

    // Retrigger and config change mid-train have no effect.
    set_cfg(2, 3, 2, 3);
    cyc(1'b1, 1'b1);
    idle(4);
    cfg_width = 4'd9;
    cyc(1'b1, 1'b1);
    idle(20);

    // Abort during the second pulse, then ignored and fresh triggers.
    set_cfg(1, 2, 2, 4);
    cyc(1'b1, 1'b1);
    idle(5);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    idle(24);

    // Asynchronous reset in the middle of a long pulse.
    set_cfg(0, 8, 0, 1);
    cyc(1'b1, 1'b1);
    idle(3);
    async_reset_mid();
    set_cfg(3, 2, 0, 1);
    idle(2);
    cyc(1'b1, 1'b1);
    idle(10);

    // 255-pulse train with trigger held high, saturating the drop counter.
    set_cfg(0, 1, 1, 255);
    for (int i = 0; i < 520; i++) cyc(1'b1, 1'b1);
    idle(520);
    async_reset_mid();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 15) == 0) begin
          set_cfg($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 10),
                  $urandom_range(0, 10));
        end else begin
          set_cfg($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 5));
        end
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) != 0);
      if ($urandom_range(0, 499) == 0) async_reset_mid();
    end

    idle(3);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
